// File: rtl/bcd_pkg.sv
// Shared types and helpers for the binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int DIG_W = 4;

  // Double-dabble correction: a digit of 5 or more overflows past 9 once doubled.
  function automatic logic [DIG_W-1:0] bcd_adj3(input logic [DIG_W-1:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the add-3 correction stage, purely combinational.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] digit,
  output logic [DIG_W-1:0] adj
);

  assign adj = bcd_adj3(digit);

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// state  | meaning
// IDLE   | waiting for start_i, outputs hold last result
// SHIFT  | one adjust+shift per cycle, BIN_W cycles
// FINISH | compute digit count, publish result on exit edge
module bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [BIN_W-1:0]             bin_i,
  output logic [DIG_W*DIGITS-1:0]      bcd_o,
  output logic [$clog2(DIGITS+1)-1:0]  ndig_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int ACC_W  = DIG_W * DIGITS;
  localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int NDIG_W = $clog2(DIGITS+1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  if (BIN_W < 1) begin : g_bin_w_chk
    $error("bin_to_bcd: BIN_W must be at least 1");
  end
  if (DIGITS < ((BIN_W * 1233) >> 12) + 1) begin : g_digits_chk
    $error("bin_to_bcd: DIGITS too small to hold the largest BIN_W-bit value");
  end

  state_t             state;
  logic [BIN_W-1:0]   shreg;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_adj;
  logic [CNT_W-1:0]   cnt;
  logic [NDIG_W-1:0]  ndig_calc;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (acc[k*DIG_W +: DIG_W]),
      .adj   (acc_adj[k*DIG_W +: DIG_W])
    );
  end

  // Highest nonzero digit wins; an all-zero result still prints one digit.
  always_comb begin
    ndig_calc = NDIG_W'(1);
    for (int k = 0; k < DIGITS; k++) begin
      if (acc[k*DIG_W +: DIG_W] != '0) ndig_calc = NDIG_W'(k + 1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      shreg  <= '0;
      acc    <= '0;
      cnt    <= '0;
      bcd_o  <= '0;
      ndig_o <= NDIG_W'(1);
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !busy_o) begin
            shreg  <= bin_i;
            acc    <= '0;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= {acc_adj[ACC_W-2:0], shreg[BIN_W-1]};
          shreg <= shreg << 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) state <= FINISH;
        end
        FINISH: begin
          bcd_o  <= acc;
          ndig_o <= ndig_calc;
          busy_o <= 1'b0;
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
